// File: rtl/servo_pwm_array_if.sv
// Register-write bus between the host-side register master and servo_pwm_array.
interface servo_pwm_array_if #(
    parameter int AW = 3
) ();
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
    logic          wr_err;
    logic          clamped;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, wr_err, clamped
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, wr_err, clamped
    );
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator. Widths and the enable mask are
// written to pending registers and copied to the active set only at the frame
// boundary, so an output pulse is never cut short or stretched mid-frame.
module servo_pwm_array #(
    parameter int NUM_CH    = 4,
    parameter int AW        = 3,
    parameter int TICK_DIV  = 100,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int CENTER_US = 1500
) (
    input  logic                clk,
    input  logic                rst,
    servo_pwm_array_if.slave    bus,
    output logic                frame_start,
    output logic [NUM_CH-1:0]   signal
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(PERIOD_US - 1);
    localparam logic [15:0]   W_MIN   = 16'(MIN_US);
    localparam logic [15:0]   W_MAX   = 16'(MAX_US);
    localparam logic [15:0]   W_CTR   = 16'(CENTER_US);
    localparam logic [AW-1:0] EN_ADDR = AW'(NUM_CH);

    logic [PW-1:0]     pcnt;
    logic [FW-1:0]     fcnt;
    logic [FW-1:0]     fcnt_nxt;
    logic              tick;
    logic              boundary;

    logic [15:0]       pend_w [NUM_CH];
    logic [15:0]       act_w  [NUM_CH];
    logic [NUM_CH-1:0] pend_en;
    logic [NUM_CH-1:0] act_en;

    logic              addr_is_ch;
    logic              addr_is_en;
    logic [15:0]       wr_val;
    logic              wr_clip;
    logic [15:0]       rd_val;
    logic [NUM_CH-1:0] sig_nxt;

    // Tick and frame-boundary decode, next frame-counter value
    always_comb begin
        tick     = (pcnt == P_LAST);
        boundary = tick && (fcnt == F_LAST);
        if (boundary)
            fcnt_nxt = '0;
        else if (tick)
            fcnt_nxt = fcnt + 1'b1;
        else
            fcnt_nxt = fcnt;
    end

    // Prescaler and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            fcnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            fcnt <= fcnt_nxt;
        end
    end

    // Address decode, width clamping and readback mux
    always_comb begin
        addr_is_ch = (bus.addr < EN_ADDR);
        addr_is_en = (bus.addr == EN_ADDR);
        wr_clip    = 1'b0;
        wr_val     = bus.wdata;
        if (bus.wdata < W_MIN) begin
            wr_val  = W_MIN;
            wr_clip = 1'b1;
        end else if (bus.wdata > W_MAX) begin
            wr_val  = W_MAX;
            wr_clip = 1'b1;
        end
        rd_val = '0;
        if (addr_is_en)
            rd_val = 16'(pend_en);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.addr == AW'(i))
                rd_val = pend_w[i];
        end
    end

    // Pending register writes; last write in a frame wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                pend_w[i] <= W_CTR;
            pend_en <= '0;
        end else if (bus.wr_en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (bus.addr == AW'(i))
                    pend_w[i] <= wr_val;
            end
            if (addr_is_en)
                pend_en <= bus.wdata[NUM_CH-1:0];
        end
    end

    // Bus responses: error/clamp pulses and read data (write takes priority)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata   <= '0;
            bus.wr_err  <= 1'b0;
            bus.clamped <= 1'b0;
        end else begin
            bus.wr_err  <= bus.wr_en && !addr_is_ch && !addr_is_en;
            bus.clamped <= bus.wr_en && addr_is_ch && wr_clip;
            if (bus.rd_en && !bus.wr_en)
                bus.rdata <= rd_val;
        end
    end

    // Active set reloads from pending (pre-write values) at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                act_w[i] <= W_CTR;
            act_en <= '0;
        end else if (boundary) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                act_w[i] <= pend_w[i];
            act_en <= pend_en;
        end
    end

    // Next output level; uses the values the active set will hold after this
    // edge so the first pulse of a frame lines up with frame_start
    always_comb begin
        sig_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (boundary)
                sig_nxt[i] = pend_en[i] && (16'(fcnt_nxt) < pend_w[i]);
            else
                sig_nxt[i] = act_en[i] && (16'(fcnt_nxt) < act_w[i]);
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signal      <= '0;
            frame_start <= 1'b0;
        end else begin
            signal      <= sig_nxt;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array: register table, frame-level
// sequences and random traffic against a cycle-count based reference model.
module tb_servo_pwm_array;

    localparam int NCH   = 4;
    localparam int AW    = 3;
    localparam int TD    = 4;
    localparam int PER   = 100;
    localparam int WMIN  = 10;
    localparam int WMAX  = 50;
    localparam int WCTR  = 30;
    localparam int FRAME = TD * PER;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           frame_start;
    logic [NCH-1:0] signal;

    servo_pwm_array_if #(.AW(AW)) bus ();

    servo_pwm_array #(
        .NUM_CH(NCH), .AW(AW), .TICK_DIV(TD), .PERIOD_US(PER),
        .MIN_US(WMIN), .MAX_US(WMAX), .CENTER_US(WCTR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .frame_start(frame_start), .signal(signal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: k counts clock edges since reset release
    int             m_pw [NCH];
    int             m_aw [NCH];
    logic [NCH-1:0] m_pe, m_ae, m_sig;
    int             m_k;
    logic [15:0]    m_rd;
    logic           m_err, m_clp, m_fs;

    int hi [NCH];
    int len;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [15:0]   exp_rdata;
        logic          exp_err;
        logic          exp_clp;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", nm, act, exp, m_k, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pw[i] = WCTR;
            m_aw[i] = WCTR;
        end
        m_pe = '0; m_ae = '0; m_sig = '0;
        m_k = 0; m_rd = '0;
        m_err = 1'b0; m_clp = 1'b0; m_fs = 1'b0;
    endfunction

    function automatic void model_step(input logic wr, input logic rd,
                                       input logic [AW-1:0] a, input logic [15:0] d);
        int v;
        int ai;
        ai = int'(a);
        m_k++;
        m_fs = (m_k % FRAME == 0);
        if (m_fs) begin
            m_aw = m_pw;
            m_ae = m_pe;
        end
        m_err = 1'b0;
        m_clp = 1'b0;
        if (wr) begin
            if (ai < NCH) begin
                v = int'(d);
                if (v < WMIN) begin v = WMIN; m_clp = 1'b1; end
                else if (v > WMAX) begin v = WMAX; m_clp = 1'b1; end
                m_pw[ai] = v;
            end else if (ai == NCH) begin
                m_pe = d[NCH-1:0];
            end else begin
                m_err = 1'b1;
            end
        end else if (rd) begin
            if (ai < NCH)       m_rd = 16'(m_pw[ai]);
            else if (ai == NCH) m_rd = 16'(m_pe);
            else                m_rd = '0;
        end
        for (int i = 0; i < NCH; i++)
            m_sig[i] = m_ae[i] && ((m_k % FRAME) < TD * m_aw[i]);
    endfunction

    task automatic cycle(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [15:0] d);
        bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        model_step(wr, rd, a, d);
        #1;
        check("signal", 32'(signal), 32'(m_sig));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("rdata", 32'(bus.rdata), 32'(m_rd));
        check("wr_err", 32'(bus.wr_err), 32'(m_err));
        check("clamped", 32'(bus.clamped), 32'(m_clp));
    endtask

    task automatic wait_next_fs();
        int n;
        n = 0;
        do begin
            cycle(1'b0, 1'b0, '0, '0);
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        if (frame_start !== 1'b1)
            check("wait_fs_timeout", 32'(n), 32'(FRAME));
    endtask

    // Runs from the current frame_start cycle to the next one, counting high
    // cycles per channel; an optional write is issued at offset wr_at.
    task automatic run_frame(input int wr_at, input logic [AW-1:0] a, input logic [15:0] d);
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        len = 0;
        do begin
            for (int i = 0; i < NCH; i++) hi[i] += int'(signal[i]);
            if (len == wr_at) cycle(1'b1, 1'b0, a, d);
            else              cycle(1'b0, 1'b0, '0, '0);
            len++;
        end while (frame_start !== 1'b1 && len < 2 * FRAME);
    endtask

    task automatic expect_frame(input string nm, input int e0, input int e1, input int e2, input int e3);
        check({nm, "_len"}, 32'(len), 32'(FRAME));
        check({nm, "_hi0"}, 32'(hi[0]), 32'(e0));
        check({nm, "_hi1"}, 32'(hi[1]), 32'(e1));
        check({nm, "_hi2"}, 32'(hi[2]), 32'(e2));
        check({nm, "_hi3"}, 32'(hi[3]), 32'(e3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic wr, rd;
        logic [AW-1:0] a;
        logic [15:0] d;

        vecs[0]  = '{1'b0, 1'b1, 3'd0, 16'd0,      16'd30, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd3, 16'd0,      16'd30, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd4, 16'd0,      16'd0,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd6, 16'd0,      16'd0,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd1, 16'd5,      16'd0,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'd1, 16'd0,      16'd10, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 16'd60,     16'd10, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 3'd1, 16'd0,      16'd50, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd1, 16'd25,     16'd50, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 16'd0,      16'd25, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd5, 16'h1234,   16'd25, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'd5, 16'd0,      16'd0,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3'd2, 16'd45,     16'd0,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'd2, 16'd0,      16'd45, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'd4, 16'hFFF9,   16'd45, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'd4, 16'd0,      16'd9,  1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'd0, 16'd20,     16'd9,  1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'd3, 16'd50,     16'd9,  1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'd2, 16'd10,     16'd9,  1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 3'd2, 16'd0,      16'd10, 1'b0, 1'b0};

        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_signal", 32'(signal), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_wr_err", 32'(bus.wr_err), 32'd0);
        check("rst_clamped", 32'(bus.clamped), 32'd0);
        rst = 1'b0;

        // Register table
        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_wr_err", i), 32'(bus.wr_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_clamped", i), 32'(bus.clamped), 32'(vecs[i].exp_clp));
        end

        // Basic PWM: ch0=20us, ch3=50us, mask 1001
        wait_next_fs();
        run_frame(-1, '0, '0);
        expect_frame("basic", 80, 0, 0, 200);

        // Mid-frame write does not disturb the current pulse
        run_frame(40, 3'd0, 16'd40);
        expect_frame("sync_cur", 80, 0, 0, 200);
        run_frame(-1, '0, '0);
        expect_frame("sync_next", 160, 0, 0, 200);

        // Write on the boundary cycle takes one extra frame
        run_frame(FRAME - 1, 3'd0, 16'd20);
        expect_frame("bnd_cur", 160, 0, 0, 200);
        run_frame(-1, '0, '0);
        expect_frame("bnd_next", 160, 0, 0, 200);
        run_frame(-1, '0, '0);
        expect_frame("bnd_after", 80, 0, 0, 200);

        // Disable while ch0 is high: pulse completes, then stays low
        run_frame(20, 3'd4, 16'd0);
        expect_frame("dis_cur", 80, 0, 0, 200);
        run_frame(-1, '0, '0);
        expect_frame("dis_next", 0, 0, 0, 0);

        // Reset mid-pulse
        run_frame(5, 3'd4, 16'd9);
        expect_frame("reen", 0, 0, 0, 0);
        repeat (10) cycle(1'b0, 1'b0, '0, '0);
        check("pre_rst_sig0", 32'(signal[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_signal", 32'(signal), 32'd0);
        check("async_rst_rdata", 32'(bus.rdata), 32'd0);
        check("async_rst_fs", 32'(frame_start), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        do begin
            cycle(1'b0, 1'b0, '0, '0);
            cnt++;
        end while (frame_start !== 1'b1 && cnt < 2 * FRAME);
        check("first_fs_after_rst", 32'(cnt), 32'(FRAME));
        for (int i = 0; i <= NCH; i++) begin
            cycle(1'b0, 1'b1, AW'(i), '0);
            check($sformatf("rst_rd%0d", i), 32'(bus.rdata), (i < NCH) ? 32'(WCTR) : 32'd0);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wr = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 3) == 0);
            a  = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d = 16'($urandom);
            else                           d = 16'($urandom_range(0, 70));
            cycle(wr, rd, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
